// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the sequencer / ControlUnit pair: stage codes,
// next-PC source encodings and the opcodes the sequencer cares about.
package pc_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IF  = 3'b000,
    ST_ID  = 3'b001,
    ST_EX  = 3'b010,
    ST_MEM = 3'b011,
    ST_WB  = 3'b100
  } stage_e;

  typedef enum logic [1:0] {
    PCS_INC  = 2'b00,
    PCS_BR   = 2'b01,
    PCS_JMP  = 2'b10,
    PCS_HOLD = 2'b11
  } pc_src_e;

  localparam logic [5:0] OP_JMP  = 6'b001100;
  localparam logic [5:0] OP_CALL = 6'b001101;
  localparam logic [5:0] OP_RET  = 6'b001110;
  localparam logic [5:0] OP_LW   = 6'b000101;
  localparam logic [5:0] OP_SW   = 6'b000111;
  localparam logic [5:0] OP_BEQ  = 6'b001010;

  // Codes above WB are not stages; the sequencer falls back to IF on them.
  function automatic logic stage_legal(input logic [2:0] s);
    return s <= ST_WB;
  endfunction

endpackage

// File: rtl/pc_sequencer_ret_stack.sv
// Hardware return-address stack: registered storage, combinational top.
// Overflowing pushes and underflowing pops are dropped; callers flag them.
module pc_sequencer_ret_stack #(
  parameter  int DEPTH = 8,
  parameter  int W     = 32,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  push_data,
  output logic [W-1:0]  top,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);
  localparam int AW = $clog2(DEPTH);

  logic [CW-1:0] count_q, count_d;
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_idx, top_idx;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign wr_idx  = count_q[AW-1:0];
  assign top_idx = count_q[AW-1:0] - AW'(1);
  assign top     = empty ? '0 : mem_q[top_idx];
  assign count   = count_q;

  always_comb begin
    count_d = count_q;
    if (push && !full)      count_d = count_q + CW'(1);
    else if (pop && !empty) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset) count_q <= '0;
    else        count_q <= count_d;
  end

  // Contents need no reset; a reset abandons any push in flight.
  always_ff @(posedge clk) begin
    if (reset && push && !full) mem_q[wr_idx] <= push_data;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Stage register, PC, instruction register and return stack feeding the
// multicycle ControlUnit. The PC and stack change only on instruction commit.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter  int               PC_W        = 32,
  parameter  int               INSTR_W     = 32,
  parameter  int               STACK_DEPTH = 8,
  parameter  logic [PC_W-1:0]  RESET_PC    = '0,
  localparam int               CW          = $clog2(STACK_DEPTH) + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [2:0]         next_state,
  input  logic [1:0]         PC_src,
  input  logic               j_src,
  input  logic [PC_W-1:0]    branch_off,
  input  logic [PC_W-1:0]    jump_target,
  input  logic [INSTR_W-1:0] instr_in,
  output logic [2:0]         state,
  output logic [PC_W-1:0]    pc,
  output logic [INSTR_W-1:0] ir,
  output logic [5:0]         opcode,
  output logic [CW-1:0]      stk_count,
  output logic               stk_ovf,
  output logic               stk_unf
);

  stage_e             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic               ovf_q, ovf_d, unf_q, unf_d;

  logic               commit, push, pop;
  logic               stk_full, stk_empty;
  logic [PC_W-1:0]    stk_top, pc_inc;

  assign opcode = ir_q[INSTR_W-1 -: 6];
  assign commit = (state_q != ST_IF) && (next_state == ST_IF);
  assign pc_inc = pc_q + PC_W'(1);

  always_comb begin
    state_d = stage_legal(next_state) ? stage_e'(next_state) : ST_IF;
    ir_d    = (state_q == ST_IF) ? instr_in : ir_q;
    pc_d    = pc_q;
    push    = 1'b0;
    pop     = 1'b0;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    if (commit) begin
      if (opcode == OP_CALL) begin
        // CALL always jumps; the return address is simply lost when full.
        pc_d = jump_target;
        if (stk_full) ovf_d = 1'b1;
        else          push  = 1'b1;
      end else begin
        unique case (pc_src_e'(PC_src))
          PCS_INC:  pc_d = pc_inc;
          PCS_BR:   pc_d = pc_q + branch_off;
          PCS_JMP: begin
            if (!j_src)                pc_d = jump_target;
            else if (opcode != OP_RET) pc_d = stk_top;
            else if (stk_empty) begin
              pc_d  = pc_inc;
              unf_d = 1'b1;
            end else begin
              pc_d = stk_top;
              pop  = 1'b1;
            end
          end
          PCS_HOLD: pc_d = pc_q;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IF;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  pc_sequencer_ret_stack #(.DEPTH(STACK_DEPTH), .W(PC_W)) u_ret_stack (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .push_data (pc_inc),
    .top       (stk_top),
    .count     (stk_count),
    .full      (stk_full),
    .empty     (stk_empty)
  );

  assign state   = state_q;
  assign pc      = pc_q;
  assign ir      = ir_q;
  assign stk_ovf = ovf_q;
  assign stk_unf = unf_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: an instruction-level model with a queue as
// the return stack is checked every cycle, plus literal checkpoints.
module tb_pc_sequencer;

  localparam logic [5:0] R_OP = 6'b000000, JMP = 6'b001100, CALL = 6'b001101,
                         RET = 6'b001110, BEQ = 6'b001010;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  next_state;
  logic [1:0]  PC_src;
  logic        j_src;
  logic [31:0] branch_off, jump_target, instr_in;
  logic [2:0]  state;
  logic [31:0] pc, ir;
  logic [5:0]  opcode;
  logic [3:0]  stk_count;
  logic        stk_ovf, stk_unf;

  pc_sequencer dut (
    .clk(clk), .reset(reset), .next_state(next_state), .PC_src(PC_src),
    .j_src(j_src), .branch_off(branch_off), .jump_target(jump_target),
    .instr_in(instr_in), .state(state), .pc(pc), .ir(ir), .opcode(opcode),
    .stk_count(stk_count), .stk_ovf(stk_ovf), .stk_unf(stk_unf)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Instruction-level reference model
  logic [2:0]  m_stage;
  logic [31:0] m_pc, m_ir, m_npc;
  logic [31:0] m_stk[$];
  logic        m_ovf, m_unf, m_commit;
  logic [5:0]  m_op;

  always @(posedge clk) begin
    if (!reset) begin
      m_stage = 3'd0; m_pc = 32'd0; m_ir = 32'd0;
      m_stk.delete(); m_ovf = 1'b0; m_unf = 1'b0;
    end else begin
      m_op     = m_ir[31:26];
      m_commit = (m_stage != 3'd0) && (next_state == 3'd0);
      m_npc    = m_pc;
      if (m_commit) begin
        if (m_op == CALL) begin
          if (m_stk.size() < 8) m_stk.push_back(m_pc + 32'd1);
          else                  m_ovf = 1'b1;
          m_npc = jump_target;
        end else begin
          case (PC_src)
            2'd0: m_npc = m_pc + 32'd1;
            2'd1: m_npc = m_pc + branch_off;
            2'd2: begin
              if (!j_src) m_npc = jump_target;
              else if (m_op == RET) begin
                if (m_stk.size() == 0) begin m_unf = 1'b1; m_npc = m_pc + 32'd1; end
                else m_npc = m_stk.pop_back();
              end else m_npc = (m_stk.size() != 0) ? m_stk[$] : 32'd0;
            end
            default: m_npc = m_pc;
          endcase
        end
      end
      if (m_stage == 3'd0) m_ir = instr_in;
      m_pc    = m_npc;
      m_stage = (next_state > 3'd4) ? 3'd0 : next_state;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("state", state, m_stage);
      chk("pc", pc, m_pc);
      chk("ir", ir, m_ir);
      chk("opcode", opcode, m_ir[31:26]);
      chk("stk_count", stk_count, m_stk.size());
      chk("stk_ovf", stk_ovf, m_ovf);
      chk("stk_unf", stk_unf, m_unf);
    end
  end

  task automatic junk_ctl();
    PC_src = 2'($urandom); j_src = 1'($urandom);
    branch_off = $urandom; jump_target = $urandom;
  endtask

  // One instruction: IF->ID->EX->WB->IF, control sampled only at the last step.
  task automatic run_instr(input logic [5:0] op, input logic [1:0] ps, input logic js,
                           input logic [31:0] off, input logic [31:0] jt);
    @(negedge clk); next_state = 3'd1; instr_in = {op, 26'($urandom)}; junk_ctl();
    @(negedge clk); next_state = 3'd2; instr_in = $urandom; junk_ctl();
    @(negedge clk); next_state = 3'd4; instr_in = $urandom; junk_ctl();
    @(negedge clk); next_state = 3'd0; instr_in = $urandom;
    PC_src = ps; j_src = js; branch_off = off; jump_target = jt;
    @(posedge clk); #1;
  endtask

  task automatic jmp(input logic [31:0] t);
    run_instr(JMP, 2'b10, 1'b0, 32'd0, t);
  endtask

  initial begin
    reset = 1'b0; next_state = 3'($urandom); instr_in = $urandom; junk_ctl();
    @(negedge clk); next_state = 3'($urandom); instr_in = $urandom; junk_ctl();
    @(posedge clk); #1;
    chk("rst_state", state, 3'd0); chk("rst_pc", pc, 32'd0); chk("rst_ir", ir, 32'd0);
    chk("rst_cnt", stk_count, 4'd0); chk("rst_ovf", stk_ovf, 1'b0); chk("rst_unf", stk_unf, 1'b0);
    chk_en = 1'b1;

    // Idle in IF with next_state==IF: must not commit.
    @(negedge clk); reset = 1'b1; next_state = 3'd0; PC_src = 2'b00;
    @(posedge clk); #1; chk("idle_pc", pc, 32'd0);

    jmp(32'd5);                 chk("jmp5_pc", pc, 32'd5);
    run_instr(R_OP, 2'b00, 1'b0, 32'd0, 32'd0);
    chk("rtype_pc", pc, 32'd6); chk("rtype_op", opcode, R_OP);

    jmp(32'd10);
    run_instr(BEQ, 2'b01, 1'b0, 32'hFFFF_FFFD, 32'd0); chk("beq_taken", pc, 32'd7);
    jmp(32'd10);
    run_instr(BEQ, 2'b11, 1'b0, 32'hFFFF_FFFD, 32'd0); chk("beq_hold", pc, 32'd10);

    jmp(32'd20);
    run_instr(CALL, 2'b00, 1'b0, 32'd0, 32'd100);
    chk("call_pc", pc, 32'd100); chk("call_cnt", stk_count, 4'd1);
    run_instr(RET, 2'b10, 1'b1, 32'd0, 32'd0);
    chk("ret_pc", pc, 32'd21); chk("ret_cnt", stk_count, 4'd0);

    for (int i = 0; i < 9; i++) run_instr(CALL, 2'($urandom), 1'($urandom), 32'd0, 32'd200 + i);
    chk("ovf_cnt", stk_count, 4'd8); chk("ovf_flag", stk_ovf, 1'b1); chk("ovf_pc", pc, 32'd208);
    run_instr(RET, 2'b10, 1'b1, 32'd0, 32'd0); chk("pop_top", pc, 32'd207);
    for (int i = 0; i < 7; i++) run_instr(RET, 2'b10, 1'b1, 32'd0, 32'd0);
    chk("pop_last", pc, 32'd22); chk("pop_cnt", stk_count, 4'd0);
    run_instr(RET, 2'b10, 1'b1, 32'd0, 32'd0);
    chk("unf_pc", pc, 32'd23); chk("unf_flag", stk_unf, 1'b1);

    // Illegal stage code mid-instruction
    @(negedge clk); next_state = 3'd1; instr_in = {R_OP, 26'd0};
    @(negedge clk); next_state = 3'b111; junk_ctl();
    @(posedge clk); #1; chk("ill_state", state, 3'd0); chk("ill_pc", pc, 32'd23);

    jmp(32'hFFFF_FFFF);
    run_instr(R_OP, 2'b00, 1'b0, 32'd0, 32'd0); chk("wrap_pc", pc, 32'd0);

    // Reset during a CALL's EX stage, with one entry already on the stack
    run_instr(CALL, 2'b00, 1'b0, 32'd0, 32'd60);
    @(negedge clk); next_state = 3'd1; instr_in = {CALL, 26'd0};
    @(negedge clk); next_state = 3'd2; junk_ctl();
    @(negedge clk); reset = 1'b0; next_state = 3'd0; jump_target = 32'd77;
    @(posedge clk); #1;
    chk("mid_rst_pc", pc, 32'd0); chk("mid_rst_cnt", stk_count, 4'd0); chk("mid_rst_state", state, 3'd0);
    @(negedge clk); reset = 1'b1;
    run_instr(R_OP, 2'b00, 1'b0, 32'd0, 32'd0); chk("post_rst_pc", pc, 32'd1);

    @(negedge clk); chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
